// File: rtl/mu0_reg16.sv
// MU0 datapath storage register (accumulator / PC / IR): enabled load, async active-high reset.
// Define MU0_REG16_CHECK_EN to add simulation-only input and shadow-model checks.
module mu0_reg16 #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  // Reset takes priority over the enable, which takes priority over hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q <= RESET_VALUE;
    end else if (En) begin
      r_q <= D;
    end
  end

  assign Q = r_q;

`ifdef MU0_REG16_CHECK_EN
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_vld;

  // Shadow copy tracks what Q should hold; it only becomes trusted after the first reset.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shadow     <= RESET_VALUE;
      r_shadow_vld <= 1'b1;
    end else begin
      if ($isunknown(En)) begin
        $error("mu0_reg16: En is X/Z at rising Clk");
      end else if (En && $isunknown(D)) begin
        $error("mu0_reg16: D has X/Z bits while En=1 (D=%h)", D);
      end
      if ((r_shadow_vld === 1'b1) && (Q !== r_shadow)) begin
        $error("mu0_reg16: Q=%h differs from shadow=%h", Q, r_shadow);
      end
      if (En === 1'b1) begin
        r_shadow <= D;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mu0_reg16.sv
// Directed bench for mu0_reg16: expected Q values queued as stimulus is driven, popped at each check.
`timescale 1ns/1ps
module tb_mu0_reg16;

  logic        Clk;
  logic        Reset;
  logic        En;
  logic [15:0] D;
  logic [15:0] Q;

  logic [15:0] sb[$];
  int          total;
  int          bad;

  mu0_reg16 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .En   (En),
    .D    (D),
    .Q    (Q)
  );

  initial Clk = 1'b0;
  always #50 Clk = ~Clk;

  task automatic push_exp(input logic [15:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag);
    logic [15:0] exp_v;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s: no expected value queued, observed=%h", tag, Q);
    end else begin
      exp_v = sb.pop_front();
      assert (Q === exp_v) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, Q, exp_v);
      end
    end
  endtask

  // Sample just after the rising edge.
  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  task automatic to_negedge();
    @(negedge Clk);
  endtask

  initial begin
    logic [15:0] pats [4];
    logic [15:0] rv;
    total = 0;
    bad   = 0;
    pats[0] = 16'h0001; pats[1] = 16'h8000; pats[2] = 16'hAAAA; pats[3] = 16'h5555;

    // Reset held with En=1 and D=FFFE: no load.
    Reset = 1'b1; En = 1'b1; D = 16'hFFFE;
    #1;
    push_exp(16'h0000); chk("reset_initial");
    edge_sample(); push_exp(16'h0000); chk("reset_edge1");
    edge_sample(); push_exp(16'h0000); chk("reset_edge2");

    // Release between edges: nothing loads until the next rising edge.
    to_negedge(); Reset = 1'b0;
    #1; push_exp(16'h0000); chk("release_no_load");
    edge_sample(); push_exp(16'hFFFE); chk("first_load");

    // Hold with En=0 while D changes.
    to_negedge(); En = 1'b0; D = 16'hFFFA;
    edge_sample(); push_exp(16'hFFFE); chk("hold_edge1");
    edge_sample(); push_exp(16'hFFFE); chk("hold_edge2");
    to_negedge(); En = 1'b1;
    edge_sample(); push_exp(16'hFFFA); chk("load_fffa");

    // Reset mid-cycle with En=0: clears immediately, before any edge.
    to_negedge(); En = 1'b0;
    #25; Reset = 1'b1;
    #1; push_exp(16'h0000); chk("async_reset_midcycle");
    edge_sample(); push_exp(16'h0000); chk("reset_over_disabled");

    // Reset beats En on a clock edge.
    to_negedge(); En = 1'b1; D = 16'hFFFA;
    edge_sample(); push_exp(16'h0000); chk("reset_over_enable");

    // Drop reset with En=1: load happens on the first edge, not before.
    to_negedge(); Reset = 1'b0;
    #1; push_exp(16'h0000); chk("release_before_edge");
    edge_sample(); push_exp(16'hFFFA); chk("load_after_release");

    // Q tracks D once per edge.
    for (int i = 0; i < 4; i++) begin
      to_negedge(); D = pats[i]; push_exp(pats[i]);
      edge_sample(); chk($sformatf("track_%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      to_negedge(); rv = 16'($urandom); D = rv; push_exp(rv);
      edge_sample(); chk($sformatf("track_rand_%0d", i));
    end

    // Hold after random traffic, then a final mid-cycle reset.
    to_negedge(); En = 1'b0; D = ~rv;
    edge_sample(); push_exp(rv); chk("hold_after_rand");
    to_negedge(); #10; Reset = 1'b1;
    #1; push_exp(16'h0000); chk("final_reset");
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
